clk_mux_ctrl: RTL and testbench

Sequencing controller for the glitch-free 2:1 PLL clock mux in the clock/reset generator. It runs on the always-on reference clock and accepts source-switch requests over a valid/ready handshake. It drives the mux select only after the target PLL reports lock, then holds the request open for a fixed settle window while the mux completes its handover. It reports completion, timeout and lock-loss errors to the CSR/power-management logic.

---
 rtl/clk_mux_ctrl_pkg.sv | 15 +
 rtl/clk_mux_ctrl_bit_sync.sv | 23 ++
 rtl/clk_mux_ctrl.sv | 110 +++++++++++
 tb/tb_clk_mux_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mux_ctrl_pkg.sv
// Shared types and source encodings for the PLL clock-mux sequencing controller.
package clk_mux_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        DONE      = 3'd3,
        ERROR     = 3'd4
    } state_t;

    localparam logic SRC_PLL1 = 1'b0;
    localparam logic SRC_PLL2 = 1'b1;

endpackage

// File: rtl/clk_mux_ctrl_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/clk_mux_ctrl.sv
// Sequences glitch-free PLL mux switches: wait for target lock, drive select, hold a settle window.
module clk_mux_ctrl
    import clk_mux_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT  = 1024,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic req_valid_i,
    input  logic req_sel_i,
    output logic req_ready_o,
    input  logic pll_1_locked_i,
    input  logic pll_2_locked_i,
    output logic sel_o,
    output logic busy_o,
    output logic done_o,
    output logic err_o
);

    localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          tgt;
    logic          prev;
    logic          lk1;
    logic          lk2;
    logic          tgt_lock;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_pll1 (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .d       (pll_1_locked_i),
        .q       (lk1)
    );

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_pll2 (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .d       (pll_2_locked_i),
        .q       (lk2)
    );

    assign tgt_lock    = (tgt == SRC_PLL2) ? lk2 : lk1;
    assign req_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE) || (state == ERROR);

    // err_o is set on the edge entering ERROR so it is already high during the done_o pulse.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state <= IDLE;
            cnt   <= '0;
            tgt   <= SRC_PLL1;
            prev  <= SRC_PLL1;
            sel_o <= SRC_PLL1;
            err_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        tgt   <= req_sel_i;
                        prev  <= sel_o;
                        err_o <= 1'b0;
                        cnt   <= '0;
                        state <= (req_sel_i == sel_o) ? DONE : WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (tgt_lock) begin
                        sel_o <= tgt;
                        cnt   <= '0;
                        state <= SETTLE;
                    end else if (cnt == LOCK_LAST) begin
                        err_o <= 1'b1;
                        cnt   <= '0;
                        state <= ERROR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SETTLE: begin
                    if (!tgt_lock) begin
                        sel_o <= prev;
                        err_o <= 1'b1;
                        cnt   <= '0;
                        state <= ERROR;
                    end else if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE, ERROR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_mux_ctrl.sv
// Self-checking bench for clk_mux_ctrl: table vectors, directed corner sequences, random transactions.
module tb_clk_mux_ctrl;

    localparam int unsigned LT = 16;
    localparam int unsigned SC = 4;
    localparam int unsigned SS = 2;

    logic clk_i = 1'b0;
    logic arst_ni;
    logic req_valid_i;
    logic req_sel_i;
    logic req_ready_o;
    logic pll_1_locked_i;
    logic pll_2_locked_i;
    logic sel_o;
    logic busy_o;
    logic done_o;
    logic err_o;

    int n_vec = 0;
    int n_err = 0;
    logic model_sel;

    typedef struct {
        logic lk1;
        logic lk2;
        logic req_sel;
        int   done_cyc;
        logic sel_chg;
        logic err;
        logic sel_after;
    } vec_t;

    vec_t tbl[8];

    clk_mux_ctrl #(
        .LOCK_TIMEOUT  (LT),
        .SETTLE_CYCLES (SC),
        .SYNC_STAGES   (SS)
    ) dut (
        .clk_i          (clk_i),
        .arst_ni        (arst_ni),
        .req_valid_i    (req_valid_i),
        .req_sel_i      (req_sel_i),
        .req_ready_o    (req_ready_o),
        .pll_1_locked_i (pll_1_locked_i),
        .pll_2_locked_i (pll_2_locked_i),
        .sel_o          (sel_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Outcome of a request with lock levels stable for the whole transaction.
    task automatic predict(input logic l1, input logic l2, input logic sel, input logic prev,
                           output int dc, output logic chg, output logic e);
        logic lk;
        lk = sel ? l2 : l1;
        if (sel == prev) begin
            dc = 1; chg = 1'b0; e = 1'b0;
        end else if (lk) begin
            dc = SC + 2; chg = 1'b1; e = 1'b0;
        end else begin
            dc = LT + 1; chg = 1'b0; e = 1'b1;
        end
    endtask

    // Called at a negedge while idle; acceptance edge is the next posedge (cycle 0).
    task automatic run_txn(input logic sel, input int dc, input logic chg, input logic e, input logic prev);
        chk("ready_before_req", req_ready_o, 1'b1);
        req_valid_i = 1'b1;
        req_sel_i   = sel;
        @(posedge clk_i);
        for (int c = 1; c <= dc + 1; c++) begin
            @(negedge clk_i);
            if (c == 1) req_valid_i = 1'b0;
            chk($sformatf("done_c%0d", c),  done_o,      (c == dc));
            chk($sformatf("busy_c%0d", c),  busy_o,      (c <= dc));
            chk($sformatf("ready_c%0d", c), req_ready_o, (c > dc));
            chk($sformatf("sel_c%0d", c),   sel_o,       (chg && c >= 2) ? sel : prev);
            chk($sformatf("err_c%0d", c),   err_o,       (e && c >= dc));
        end
    endtask

    task automatic set_locks(input logic l1, input logic l2);
        pll_1_locked_i = l1;
        pll_2_locked_i = l2;
        repeat (SS + 2) @(negedge clk_i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dc;
        logic chg;
        logic e;
        int   chg_cyc;
        int   done_cyc;
        logic err_seen;

        tbl[0] = '{1'b1, 1'b1, 1'b1, SC + 2, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1,      1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, SC + 2, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, LT + 1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1,      1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, SC + 2, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, LT + 1, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1,      1'b0, 1'b0, 1'b1};

        arst_ni        = 1'b0;
        req_valid_i    = 1'b0;
        req_sel_i      = 1'b0;
        pll_1_locked_i = 1'b1;
        pll_2_locked_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_sel", sel_o, 1'b0);
        chk("rst_ready", req_ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        arst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        model_sel = 1'b0;

        foreach (tbl[i]) begin
            set_locks(tbl[i].lk1, tbl[i].lk2);
            run_txn(tbl[i].req_sel, tbl[i].done_cyc, tbl[i].sel_chg, tbl[i].err, model_sel);
            model_sel = tbl[i].sel_after;
        end

        // Lock of PLL2 arrives asynchronously in cycle 5 of the wait.
        set_locks(1'b1, 1'b0);
        run_txn(1'b0, SC + 2, 1'b1, 1'b0, 1'b1);
        chk("ready_before_async", req_ready_o, 1'b1);
        req_valid_i = 1'b1;
        req_sel_i   = 1'b1;
        @(posedge clk_i);
        chg_cyc = 0; done_cyc = 0; err_seen = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk_i);
            if (c == 1) req_valid_i = 1'b0;
            if (sel_o && chg_cyc == 0) chg_cyc = c;
            if (done_o && done_cyc == 0) done_cyc = c;
            if (err_o) err_seen = 1'b1;
            if (c == 5) #2 pll_2_locked_i = 1'b1;
        end
        chk("async_sel_window", (chg_cyc >= 7 && chg_cyc <= 9), 1'b1);
        chk("async_done_delay", done_cyc, chg_cyc + SC);
        chk("async_no_err", err_seen, 1'b0);
        model_sel = 1'b1;

        // Lock drop in the second settle cycle, with a request held valid throughout.
        set_locks(1'b1, 1'b1);
        run_txn(1'b0, SC + 2, 1'b1, 1'b0, 1'b1);
        req_valid_i = 1'b1;
        req_sel_i   = 1'b1;
        @(posedge clk_i);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            if (c == 1) req_sel_i = 1'b0;
            chk($sformatf("drop_done_c%0d", c),  done_o,      (c == 6 || c == 8));
            chk($sformatf("drop_ready_c%0d", c), req_ready_o, (c == 7));
            chk($sformatf("drop_sel_c%0d", c),   sel_o,       (c >= 2 && c <= 5));
            chk($sformatf("drop_err_c%0d", c),   err_o,       (c == 6 || c == 7));
            if (c == 3) #2 pll_2_locked_i = 1'b0;
        end
        req_valid_i = 1'b0;
        model_sel   = 1'b0;

        // Asynchronous reset during SETTLE.
        set_locks(1'b1, 1'b1);
        req_valid_i = 1'b1;
        req_sel_i   = 1'b1;
        @(posedge clk_i);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            if (c == 1) req_valid_i = 1'b0;
            if (c == 2) chk("rstmid_sel_before", sel_o, 1'b1);
        end
        #2 arst_ni = 1'b0;
        #1;
        chk("rstmid_sel", sel_o, 1'b0);
        chk("rstmid_busy", busy_o, 1'b0);
        chk("rstmid_ready", req_ready_o, 1'b1);
        chk("rstmid_done", done_o, 1'b0);
        repeat (2) begin
            @(negedge clk_i);
            chk("rstmid_done_hold", done_o, 1'b0);
        end
        arst_ni   = 1'b1;
        model_sel = 1'b0;
        repeat (4) @(negedge clk_i);

        for (int n = 0; n < 25; n++) begin
            logic l1;
            logic l2;
            logic rs;
            l1 = 1'($urandom_range(0, 1));
            l2 = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            set_locks(l1, l2);
            predict(l1, l2, rs, model_sel, dc, chg, e);
            run_txn(rs, dc, chg, e, model_sel);
            if (chg) model_sel = rs;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
